// File: rtl/pong_renderer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_renderer_pkg
//  Description : Shared VGA timing, screen geometry and colour definitions
//                for the pong renderer and its digit font.
//  Revision    : 1.0  initial release
// ============================================================================
package pong_renderer_pkg;

    // 640x480 @ 60 Hz style timing, counted in raw pixel/line units
    localparam logic [9:0] c_H_TOTAL       = 10'd800;
    localparam logic [9:0] c_V_TOTAL       = 10'd521;
    localparam logic [9:0] c_H_SYNC        = 10'd96;
    localparam logic [9:0] c_V_SYNC        = 10'd2;
    localparam logic [9:0] c_H_VIS_START   = 10'd144;
    localparam logic [9:0] c_H_VIS_END     = 10'd784;   // exclusive
    localparam logic [9:0] c_V_VIS_START   = 10'd31;
    localparam logic [9:0] c_V_VIS_END     = 10'd511;   // exclusive

    // Score layout: 3x5 glyphs scaled by 4 -> 12x20 pixels
    localparam logic [9:0]  c_SCORE_Y0     = 10'd48;
    localparam logic [9:0]  c_SCORE_Y1     = 10'd67;
    localparam logic [10:0] c_DIGIT_SPAN   = 11'd11;    // width - 1
    localparam logic [10:0] c_P1_TENS_X    = 11'd400;
    localparam logic [10:0] c_P1_ONES_X    = 11'd416;
    localparam logic [10:0] c_P2_TENS_X    = 11'd500;
    localparam logic [10:0] c_P2_ONES_X    = 11'd516;

    // Centre net
    localparam logic [10:0] c_NET_X0       = 11'd463;
    localparam logic [10:0] c_NET_X1       = 11'd464;

    typedef struct packed {
        logic [2:0] red;
        logic [2:0] green;
        logic [1:0] blue;
    } rgb_t;

    localparam rgb_t c_RGB_BLACK = '{red: 3'd0, green: 3'd0, blue: 2'd0};
    localparam rgb_t c_RGB_WHITE = '{red: 3'd7, green: 3'd7, blue: 2'd3};
    localparam rgb_t c_RGB_GREEN = '{red: 3'd0, green: 3'd7, blue: 2'd0};
    localparam rgb_t c_RGB_GREY  = '{red: 3'd3, green: 3'd3, blue: 2'd1};

    // Drawing layers, listed from lowest to highest priority
    typedef enum logic [2:0] {
        LAYER_BG     = 3'd0,
        LAYER_NET    = 3'd1,
        LAYER_SCORE  = 3'd2,
        LAYER_PADDLE = 3'd3,
        LAYER_BALL   = 3'd4
    } layer_e;

    // Inclusive range test; all operands widened to 11 bits so that
    // position + size never wraps.
    function automatic logic in_span(input logic [10:0] v,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pong_digit_font.sv
`default_nettype none
// ============================================================================
//  Module      : pong_digit_font
//  Description : 3x5 combinational digit font. Values above 9 and
//                coordinates outside the 3x5 cell give a blank pixel.
//  Ports       : digit [3:0] in  - BCD value
//                row   [2:0] in  - glyph row 0..4 (0 = top)
//                col   [1:0] in  - glyph column 0..2 (0 = left)
//                pixel       out - 1 when the glyph pixel is lit
//  Revision    : 1.0  initial release
// ============================================================================
module pong_digit_font (
    input  logic [3:0] digit,
    input  logic [2:0] row,
    input  logic [1:0] col,
    output logic       pixel
);

    // Glyph rows packed top row first, leftmost column in the MSB of a row
    logic [14:0] w_glyph;
    logic [3:0]  w_idx;

    always_comb begin
        w_glyph = 15'd0;
        case (digit)
            4'd0:    w_glyph = 15'b111_101_101_101_111;
            4'd1:    w_glyph = 15'b010_110_010_010_111;
            4'd2:    w_glyph = 15'b111_001_111_100_111;
            4'd3:    w_glyph = 15'b111_001_111_001_111;
            4'd4:    w_glyph = 15'b101_101_111_001_001;
            4'd5:    w_glyph = 15'b111_100_111_001_111;
            4'd6:    w_glyph = 15'b111_100_111_101_111;
            4'd7:    w_glyph = 15'b111_001_001_001_001;
            4'd8:    w_glyph = 15'b111_101_111_101_111;
            4'd9:    w_glyph = 15'b111_101_111_001_111;
            default: w_glyph = 15'd0;
        endcase
    end

    always_comb begin
        w_idx = 4'd14 - (({1'b0, row} * 4'd3) + {2'b00, col});
        pixel = 1'b0;
        if ((row <= 3'd4) && (col <= 2'd2)) begin
            pixel = w_glyph[w_idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pong_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : pong_renderer
//  Description : VGA pong scene renderer. Generates 800x521 raster timing,
//                draws ball, two paddles, BCD scores and the centre net from
//                per-frame snapshots of the game state.
//  Ports       : clk                      in  system clock
//                reset                    in  asynchronous active-high reset
//                ballX[9:0], ballY[8:0]   in  ball top-left position
//                paddle1Y, paddle2Y[8:0]  in  paddle top lines
//                score_*_tens/ones[3:0]   in  BCD score digits
//                hsync, vsync             out active-low syncs
//                red[2:0] green[2:0] blue[1:0] out pixel colour
//                frame_tick               out one-clk pulse at frame start
//  Revision    : 1.0  initial release
// ============================================================================
module pong_renderer
    import pong_renderer_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int PADDLE_H = 48,
    parameter int PADDLE_W = 8,
    parameter int BALL_SZ  = 8,
    parameter int P1_X     = 160,
    parameter int P2_X     = 775
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] ballX,
    input  logic [8:0] ballY,
    input  logic [8:0] paddle1Y,
    input  logic [8:0] paddle2Y,
    input  logic [3:0] score_one_tens,
    input  logic [3:0] score_one_ones,
    input  logic [3:0] score_two_tens,
    input  logic [3:0] score_two_ones,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       frame_tick
);

    localparam int                   c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0]   c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]           c_H_LAST   = c_H_TOTAL - 10'd1;
    localparam logic [9:0]           c_V_LAST   = c_V_TOTAL - 10'd1;
    localparam logic [10:0]          c_P1_X0    = 11'(P1_X);
    localparam logic [10:0]          c_P1_X1    = 11'(P1_X + PADDLE_W - 1);
    localparam logic [10:0]          c_P2_X0    = 11'(P2_X);
    localparam logic [10:0]          c_P2_X1    = 11'(P2_X + PADDLE_W - 1);

    // ------------------------------------------------------------------
    // Pixel divider and raster counters
    // ------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div;
    logic [9:0]         r_hcount;
    logic [9:0]         r_vcount;
    logic               w_pix_en;
    logic               w_snap;

    assign w_pix_en = (r_div == c_DIV_LAST);
    assign w_snap   = w_pix_en && (r_hcount == 10'd0) && (r_vcount == 10'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_pix_en) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hcount <= 10'd0;
            r_vcount <= 10'd0;
        end else if (w_pix_en) begin
            if (r_hcount == c_H_LAST) begin
                r_hcount <= 10'd0;
                r_vcount <= (r_vcount == c_V_LAST) ? 10'd0 : r_vcount + 10'd1;
            end else begin
                r_hcount <= r_hcount + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame-start snapshots: the whole frame is drawn from these so that
    // input changes mid-frame never tear the picture.
    // ------------------------------------------------------------------
    logic [9:0] r_ball_x;
    logic [8:0] r_ball_y;
    logic [8:0] r_pad1_y;
    logic [8:0] r_pad2_y;
    logic [3:0] r_s1_tens;
    logic [3:0] r_s1_ones;
    logic [3:0] r_s2_tens;
    logic [3:0] r_s2_ones;
    logic       r_frame_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ball_x     <= 10'd0;
            r_ball_y     <= 9'd0;
            r_pad1_y     <= 9'd0;
            r_pad2_y     <= 9'd0;
            r_s1_tens    <= 4'd0;
            r_s1_ones    <= 4'd0;
            r_s2_tens    <= 4'd0;
            r_s2_ones    <= 4'd0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_snap;
            if (w_snap) begin
                r_ball_x  <= ballX;
                r_ball_y  <= ballY;
                r_pad1_y  <= paddle1Y;
                r_pad2_y  <= paddle2Y;
                r_s1_tens <= score_one_tens;
                r_s1_ones <= score_one_ones;
                r_s2_tens <= score_two_tens;
                r_s2_ones <= score_two_ones;
            end
        end
    end

    // ------------------------------------------------------------------
    // Object hit tests (screen coordinates equal raw counters)
    // ------------------------------------------------------------------
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic        w_visible;
    logic        w_ball_hit;
    logic        w_paddle_hit;
    logic        w_net_hit;

    assign w_x = {1'b0, r_hcount};
    assign w_y = {1'b0, r_vcount};

    assign w_visible = (r_hcount >= c_H_VIS_START) && (r_hcount < c_H_VIS_END) &&
                       (r_vcount >= c_V_VIS_START) && (r_vcount < c_V_VIS_END);

    assign w_ball_hit =
        in_span(w_x, {1'b0, r_ball_x}, {1'b0, r_ball_x} + 11'(BALL_SZ - 1)) &&
        in_span(w_y, {2'b00, r_ball_y}, {2'b00, r_ball_y} + 11'(BALL_SZ - 1));

    assign w_paddle_hit =
        (in_span(w_x, c_P1_X0, c_P1_X1) &&
         in_span(w_y, {2'b00, r_pad1_y}, {2'b00, r_pad1_y} + 11'(PADDLE_H - 1))) ||
        (in_span(w_x, c_P2_X0, c_P2_X1) &&
         in_span(w_y, {2'b00, r_pad2_y}, {2'b00, r_pad2_y} + 11'(PADDLE_H - 1)));

    // Net is dashed in 8-line segments
    assign w_net_hit = in_span(w_x, c_NET_X0, c_NET_X1) && !r_vcount[3];

    // ------------------------------------------------------------------
    // Score digits: the four cells never overlap, so one font lookup is
    // shared and fed by whichever cell the beam is in.
    // ------------------------------------------------------------------
    logic       w_in_score_y;
    logic       w_in_cell;
    logic [3:0] w_digit;
    logic [2:0] w_row;
    logic [1:0] w_col;
    logic       w_font_px;
    logic       w_score_hit;

    assign w_in_score_y = (r_vcount >= c_SCORE_Y0) && (r_vcount <= c_SCORE_Y1);
    assign w_row        = 3'((r_vcount - c_SCORE_Y0) >> 2);

    always_comb begin
        w_in_cell = 1'b0;
        w_digit   = 4'hF;
        w_col     = 2'd0;
        if (in_span(w_x, c_P1_TENS_X, c_P1_TENS_X + c_DIGIT_SPAN)) begin
            w_in_cell = 1'b1;
            w_digit   = r_s1_tens;
            w_col     = 2'((w_x - c_P1_TENS_X) >> 2);
        end else if (in_span(w_x, c_P1_ONES_X, c_P1_ONES_X + c_DIGIT_SPAN)) begin
            w_in_cell = 1'b1;
            w_digit   = r_s1_ones;
            w_col     = 2'((w_x - c_P1_ONES_X) >> 2);
        end else if (in_span(w_x, c_P2_TENS_X, c_P2_TENS_X + c_DIGIT_SPAN)) begin
            w_in_cell = 1'b1;
            w_digit   = r_s2_tens;
            w_col     = 2'((w_x - c_P2_TENS_X) >> 2);
        end else if (in_span(w_x, c_P2_ONES_X, c_P2_ONES_X + c_DIGIT_SPAN)) begin
            w_in_cell = 1'b1;
            w_digit   = r_s2_ones;
            w_col     = 2'((w_x - c_P2_ONES_X) >> 2);
        end
    end

    pong_digit_font u_font (
        .digit (w_digit),
        .row   (w_row),
        .col   (w_col),
        .pixel (w_font_px)
    );

    assign w_score_hit = w_in_score_y && w_in_cell && w_font_px;

    // ------------------------------------------------------------------
    // Layer priority and colour
    // ------------------------------------------------------------------
    layer_e w_layer;
    rgb_t   w_rgb;

    always_comb begin
        w_layer = LAYER_BG;
        if (w_ball_hit) begin
            w_layer = LAYER_BALL;
        end else if (w_paddle_hit) begin
            w_layer = LAYER_PADDLE;
        end else if (w_score_hit) begin
            w_layer = LAYER_SCORE;
        end else if (w_net_hit) begin
            w_layer = LAYER_NET;
        end
    end

    always_comb begin
        w_rgb = c_RGB_BLACK;
        if (w_visible) begin
            case (w_layer)
                LAYER_BALL:   w_rgb = c_RGB_WHITE;
                LAYER_PADDLE: w_rgb = c_RGB_GREEN;
                LAYER_SCORE:  w_rgb = c_RGB_WHITE;
                LAYER_NET:    w_rgb = c_RGB_GREY;
                default:      w_rgb = c_RGB_BLACK;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output stage: colour and syncs registered together so they stay
    // aligned, one pixel behind the counters.
    // ------------------------------------------------------------------
    logic r_hsync;
    logic r_vsync;
    rgb_t r_rgb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= c_RGB_BLACK;
        end else if (w_pix_en) begin
            r_hsync <= !(r_hcount < c_H_SYNC);
            r_vsync <= !(r_vcount < c_V_SYNC);
            r_rgb   <= w_rgb;
        end
    end

    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign red        = r_rgb.red;
    assign green      = r_rgb.green;
    assign blue       = r_rgb.blue;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire
